// File: rtl/moore_pattern_detector_if.sv
// Symbol-stream bus of moore_pattern_detector. The cnt_clr/match_cnt signals are
// present only when MOORE_MATCH_CNT_EN is defined.
interface moore_pattern_detector_if #(
   parameter int SYM_W = 2,
   parameter int LEN   = 4,
   parameter int CNT_W = 8
);
   logic                       in_valid;
   logic [SYM_W-1:0]           in;
   logic [LEN*SYM_W-1:0]       pattern;
   logic                       overlap;
   logic                       out;
   logic [$clog2(LEN+1)-1:0]   state;
`ifdef MOORE_MATCH_CNT_EN
   logic                       cnt_clr;
   logic [CNT_W-1:0]           match_cnt;

   modport master (output in_valid, in, pattern, overlap, cnt_clr,
                   input  out, state, match_cnt);
   modport slave  (input  in_valid, in, pattern, overlap, cnt_clr,
                   output out, state, match_cnt);
`else
   modport master (output in_valid, in, pattern, overlap,
                   input  out, state);
   modport slave  (input  in_valid, in, pattern, overlap,
                   output out, state);
`endif
endinterface

// File: rtl/moore_pattern_detector.sv
// Moore detector for a runtime-programmable LEN-symbol pattern with optional overlap.
// Optional saturating match counter compiled in by MOORE_MATCH_CNT_EN.
module moore_pattern_detector #(
   parameter int SYM_W = 2,
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input logic                     clk,
   input logic                     rst,
   moore_pattern_detector_if.slave bus
);
   localparam int ST_W = $clog2(LEN+1);
   localparam logic [ST_W-1:0] ST_IDLE  = '0;
   localparam logic [ST_W-1:0] ST_MATCH = ST_W'(LEN);

   // hist[0] is the newest accepted symbol; only the first fill entries are meaningful.
   logic [LEN-1:0][SYM_W-1:0] hist_q, hist_d;
   logic [ST_W-1:0]           fill_q, fill_d;
   logic [ST_W-1:0]           state_q, state_d;
   logic                      hit;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      state_d = state_q;
      hit     = 1'b0;
      if (bus.in_valid) begin
         hist_d[0] = bus.in;
         for (int j = 1; j < LEN; j++) hist_d[j] = hist_q[j-1];
         fill_d  = (fill_q == ST_MATCH) ? ST_MATCH : fill_q + ST_W'(1);
         state_d = ST_IDLE;
         // Ascending scan: the longest prefix that matches the history suffix wins.
         for (int k = 1; k <= LEN; k++) begin
            hit = (ST_W'(k) <= fill_d);
            for (int i = 0; i < k; i++)
               if (hist_d[k-1-i] != bus.pattern[i*SYM_W +: SYM_W]) hit = 1'b0;
            if (hit) state_d = ST_W'(k);
         end
         if (state_d == ST_MATCH && !bus.overlap) fill_d = ST_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fill_q  <= ST_IDLE;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   // NOTE: history storage is not reset; clearing fill makes its stale contents invisible.
   always_ff @(posedge clk) begin
      hist_q <= hist_d;
   end

   assign bus.out   = (state_q == ST_MATCH);
   assign bus.state = state_q;

`ifdef MOORE_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (bus.cnt_clr)
         cnt_q <= '0;
      else if (bus.in_valid && state_d == ST_MATCH && cnt_q != '1)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_moore_pattern_detector.sv
// Directed scoreboard bench for moore_pattern_detector; counter checks and the
// saturation instance are compiled only with MOORE_MATCH_CNT_EN.
module tb_moore_pattern_detector;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       o;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   moore_pattern_detector_if #(.SYM_W(2), .LEN(4), .CNT_W(8)) dut_if ();
   moore_pattern_detector #(.SYM_W(2), .LEN(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if)
   );

`ifdef MOORE_MATCH_CNT_EN
   moore_pattern_detector_if #(.SYM_W(2), .LEN(4), .CNT_W(2)) sat_if ();
   moore_pattern_detector #(.SYM_W(2), .LEN(4), .CNT_W(2)) sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_if)
   );
`endif

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic compare_main();
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".state"}, {5'd0, dut_if.state}, {5'd0, e.st});
      check({e.tag, ".out"}, {7'd0, dut_if.out}, {7'd0, e.o});
`ifdef MOORE_MATCH_CNT_EN
      check({e.tag, ".cnt"}, dut_if.match_cnt, e.cnt);
`endif
   endtask

   task automatic step(input logic v, input logic [1:0] sym, input logic clr, input string tag,
                       input logic [2:0] es, input logic eo, input logic [7:0] ec);
      exp_t e;
      @(negedge clk);
      dut_if.in_valid = v;
      dut_if.in       = sym;
`ifdef MOORE_MATCH_CNT_EN
      dut_if.cnt_clr  = clr;
`endif
      e = '{tag: tag, st: es, o: eo, cnt: ec};
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_main();
   endtask

`ifdef MOORE_MATCH_CNT_EN
   task automatic sat_step(input logic clr, input string tag, input logic [2:0] es, input logic [7:0] ec);
      exp_t e;
      @(negedge clk);
      sat_if.in_valid = 1'b1;
      sat_if.in       = 2'b01;
      sat_if.cnt_clr  = clr;
      e = '{tag: tag, st: es, o: (es == 3'd4), cnt: ec};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".state"}, {5'd0, sat_if.state}, {5'd0, e.st});
      check({e.tag, ".cnt"}, {6'd0, sat_if.match_cnt}, e.cnt);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      dut_if.in_valid = 1'b1;
      dut_if.in       = 2'b10;
      dut_if.pattern  = 8'b10_01_10_00;
      dut_if.overlap  = 1'b1;
`ifdef MOORE_MATCH_CNT_EN
      dut_if.cnt_clr  = 1'b0;
      sat_if.in_valid = 1'b0;
      sat_if.in       = 2'b00;
      sat_if.pattern  = 8'b01_01_01_01;
      sat_if.overlap  = 1'b1;
      sat_if.cnt_clr  = 1'b0;
`endif
      // Symbols offered during reset must be ignored.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset.state", {5'd0, dut_if.state}, 8'd0);
      check("reset.out", {7'd0, dut_if.out}, 8'd0);
`ifdef MOORE_MATCH_CNT_EN
      check("reset.cnt", dut_if.match_cnt, 8'd0);
`endif
      @(negedge clk);
      dut_if.in_valid = 1'b0;
      rst = 1'b0;

      // Basic match, then hold with in_valid low, then fresh start after the match.
      step(1, 2'b00, 0, "basic1", 3'd1, 0, 8'd0);
      step(1, 2'b10, 0, "basic2", 3'd2, 0, 8'd0);
      step(1, 2'b01, 0, "basic3", 3'd3, 0, 8'd0);
      step(1, 2'b10, 0, "basic4", 3'd4, 1, 8'd1);
      step(0, 2'b11, 0, "hold_match", 3'd4, 1, 8'd1);
      step(1, 2'b00, 0, "after_match", 3'd1, 0, 8'd1);

      // Stall then mismatch.
      step(1, 2'b10, 0, "stall_in", 3'd2, 0, 8'd1);
      step(0, 2'b01, 0, "stall1", 3'd2, 0, 8'd1);
      step(0, 2'b10, 0, "stall2", 3'd2, 0, 8'd1);
      step(0, 2'b00, 0, "stall3", 3'd2, 0, 8'd1);
      step(1, 2'b11, 0, "mismatch", 3'd0, 0, 8'd1);

      // Asynchronous reset at state 3, visible before the next clock edge.
      step(1, 2'b00, 0, "pre_rst1", 3'd1, 0, 8'd1);
      step(1, 2'b10, 0, "pre_rst2", 3'd2, 0, 8'd1);
      step(1, 2'b01, 0, "pre_rst3", 3'd3, 0, 8'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.state", {5'd0, dut_if.state}, 8'd0);
      check("async_rst.out", {7'd0, dut_if.out}, 8'd0);
`ifdef MOORE_MATCH_CNT_EN
      check("async_rst.cnt", dut_if.match_cnt, 8'd0);
`endif
      @(negedge clk);
      dut_if.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1, 2'b10, 0, "post_rst", 3'd0, 0, 8'd0);

      // Overlapping detection.
      dut_if.pattern = 8'b10_00_10_00;
      step(1, 2'b00, 0, "ovl1", 3'd1, 0, 8'd0);
      step(1, 2'b10, 0, "ovl2", 3'd2, 0, 8'd0);
      step(1, 2'b00, 0, "ovl3", 3'd3, 0, 8'd0);
      step(1, 2'b10, 0, "ovl4", 3'd4, 1, 8'd1);
      step(1, 2'b00, 0, "ovl5", 3'd3, 0, 8'd1);
      step(1, 2'b10, 0, "ovl6", 3'd4, 1, 8'd2);
      step(0, 2'b00, 1, "cnt_clr", 3'd4, 1, 8'd0);

      // Non-overlapping detection on the same pattern and stream.
      dut_if.overlap = 1'b0;
      step(1, 2'b11, 0, "flush", 3'd0, 0, 8'd0);
      step(1, 2'b00, 0, "novl1", 3'd1, 0, 8'd0);
      step(1, 2'b10, 0, "novl2", 3'd2, 0, 8'd0);
      step(1, 2'b00, 0, "novl3", 3'd3, 0, 8'd0);
      step(1, 2'b10, 0, "novl4", 3'd4, 1, 8'd1);
      step(1, 2'b00, 0, "novl5", 3'd1, 0, 8'd1);
      step(1, 2'b10, 0, "novl6", 3'd2, 0, 8'd1);
      @(negedge clk);
      dut_if.in_valid = 1'b0;

`ifdef MOORE_MATCH_CNT_EN
      // Saturation of a 2-bit counter, then clear colliding with a match.
      sat_step(0, "sat1", 3'd1, 8'd0);
      sat_step(0, "sat2", 3'd2, 8'd0);
      sat_step(0, "sat3", 3'd3, 8'd0);
      sat_step(0, "sat4", 3'd4, 8'd1);
      sat_step(0, "sat5", 3'd4, 8'd2);
      sat_step(0, "sat6", 3'd4, 8'd3);
      sat_step(0, "sat7", 3'd4, 8'd3);
      sat_step(0, "sat8", 3'd4, 8'd3);
      sat_step(1, "sat_clr", 3'd4, 8'd0);
      @(negedge clk);
      sat_if.in_valid = 1'b0;
      sat_if.cnt_clr  = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
